// File: rtl/maze_pkg.sv
// Shared maze-walker types: neighbour direction encoding and picker FSM states.
package maze_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_NORTH = 2'd0;
    localparam dir_t DIR_EAST  = 2'd1;
    localparam dir_t DIR_SOUTH = 2'd2;
    localparam dir_t DIR_WEST  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/direction_priority_encoder.sv
// Lowest-index set bit of a 4-bit neighbour mask (North wins), plus an any-set flag.
module direction_priority_encoder
    import maze_pkg::*;
(
    input  logic [3:0] mask,
    output dir_t       direction,
    output logic       any_set
);

    always_comb begin
        direction = DIR_NORTH;
        any_set   = |mask;
        if (mask[0]) begin
            direction = DIR_NORTH;
        end else if (mask[1]) begin
            direction = DIR_EAST;
        end else if (mask[2]) begin
            direction = DIR_SOUTH;
        end else if (mask[3]) begin
            direction = DIR_WEST;
        end
    end

endmodule

// File: rtl/random_neighbour_picker.sv
// Picks a random unvisited neighbour by rejection sampling an external LFSR word,
// falling back to the lowest-index unvisited neighbour after MAX_TRIES rejects.
module random_neighbour_picker
    import maze_pkg::*;
#(
    parameter int MAX_TRIES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [10:0] lfsr_value,
    input  logic        request,
    input  logic [3:0]  unvisited_mask,
    input  logic        ack,
    output logic        ready,
    output logic        valid,
    output dir_t        direction,
    output logic        dead_end,
    output logic        fallback,
    output state_t      state_dbg
);

    // Handshake: a request is taken on an edge where ready=1 (IDLE); the result is
    // presented while valid=1 (DONE) and released on an edge where ack=1.
    // Requests outside IDLE and acks outside DONE are dropped, never queued.

    if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
        $error("random_neighbour_picker: MAX_TRIES must be in 1..15");
    end

    localparam logic [3:0] MAX_TRIES_L = 4'(MAX_TRIES);

    state_t     state_q, state_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] tries_q, tries_d;
    dir_t       dir_q, dir_d;
    logic       dead_end_q, dead_end_d;
    logic       fallback_q, fallback_d;

    logic [3:0] enc_mask;
    dir_t       enc_dir;
    logic       enc_any;
    dir_t       candidate;
    logic [3:0] tries_inc;

    // One encoder serves both decisions: the live mask in IDLE (dead-end test)
    // and the latched mask in SAMPLE (fallback direction).
    assign enc_mask  = (state_q == ST_IDLE) ? unvisited_mask : mask_q;
    assign candidate = lfsr_value[1:0] ^ lfsr_value[10:9];
    assign tries_inc = tries_q + 4'd1;

    direction_priority_encoder u_enc (
        .mask      (enc_mask),
        .direction (enc_dir),
        .any_set   (enc_any)
    );

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        tries_d    = tries_q;
        dir_d      = dir_q;
        dead_end_d = dead_end_q;
        fallback_d = fallback_q;
        case (state_q)
            ST_IDLE: begin
                if (request) begin
                    mask_d     = unvisited_mask;
                    tries_d    = 4'd0;
                    dir_d      = DIR_NORTH;
                    fallback_d = 1'b0;
                    dead_end_d = !enc_any;
                    state_d    = enc_any ? ST_SAMPLE : ST_DONE;
                end
            end
            ST_SAMPLE: begin
                if (mask_q[candidate]) begin
                    dir_d      = candidate;
                    fallback_d = 1'b0;
                    state_d    = ST_DONE;
                end else begin
                    // Counter stops at MAX_TRIES (<= 15), so it cannot wrap.
                    tries_d = tries_inc;
                    if (tries_inc == MAX_TRIES_L) begin
                        dir_d      = enc_dir;
                        fallback_d = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mask_q     <= 4'd0;
            tries_q    <= 4'd0;
            dir_q      <= DIR_NORTH;
            dead_end_q <= 1'b0;
            fallback_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            tries_q    <= tries_d;
            dir_q      <= dir_d;
            dead_end_q <= dead_end_d;
            fallback_q <= fallback_d;
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign valid     = (state_q == ST_DONE);
    assign direction = dir_q;
    assign dead_end  = dead_end_q;
    assign fallback  = fallback_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_random_neighbour_picker.sv
// Self-checking bench for random_neighbour_picker against a draw-by-draw reference model.
module tb_random_neighbour_picker;
  import maze_pkg::*;

  localparam int MAX_TRIES = 8;

  logic        clock;
  logic        reset;
  logic [10:0] lfsr_value;
  logic        request;
  logic [3:0]  unvisited_mask;
  logic        ack;
  logic        ready;
  logic        valid;
  dir_t        direction;
  logic        dead_end;
  logic        fallback;
  state_t      state_dbg;

  int tests_run;
  int tests_failed;

  logic [10:0] lv_arr[20];

  random_neighbour_picker #(.MAX_TRIES(MAX_TRIES)) dut (
    .clock          (clock),
    .reset          (reset),
    .lfsr_value     (lfsr_value),
    .request        (request),
    .unvisited_mask (unvisited_mask),
    .ack            (ack),
    .ready          (ready),
    .valid          (valid),
    .direction      (direction),
    .dead_end       (dead_end),
    .fallback       (fallback),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: draw t (0-based) is seen at edge t+2; first hit wins,
  // otherwise after MAX_TRIES misses the lowest unvisited neighbour is chosen.
  function automatic void ref_model(input logic [3:0] m, output int e, output logic [1:0] d,
                                    output logic de, output logic fb);
    logic [10:0] w;
    int cand;
    e = 0; d = 2'd0; de = 1'b0; fb = 1'b0;
    if (m == 4'd0) begin
      e = 1; de = 1'b1;
      return;
    end
    for (int t = 0; t < MAX_TRIES; t++) begin
      w = lv_arr[t];
      cand = int'(w[1:0]) ^ int'(w[10:9]);
      if (m[cand]) begin
        e = t + 2; d = 2'(cand);
        return;
      end
    end
    e = MAX_TRIES + 1; fb = 1'b1;
    for (int b = 3; b >= 0; b--) if (m[b]) d = 2'(b);
  endfunction

  // driver: issue one request and count edges until valid (bounded)
  task automatic run_txn(input logic [3:0] m, output int edges);
    request = 1'b1;
    unvisited_mask = m;
    lfsr_value = lv_arr[0];
    tick();
    edges = 1;
    request = 1'b0;
    unvisited_mask = 4'($urandom);
    while (valid !== 1'b1 && edges < 20) begin
      lfsr_value = lv_arr[edges - 1];
      tick();
      edges++;
    end
  endtask

  task automatic release_result();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; request = 1'b0; ack = 1'b0; unvisited_mask = 4'd0; lfsr_value = 11'd0;
    #2;
    tests_run++;
    if (ready !== 1'b1 || valid !== 1'b0 || direction !== 2'd0 || dead_end !== 1'b0 ||
        fallback !== 1'b0 || state_dbg !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got rdy=%b vld=%b dir=%0d de=%b fb=%b st=%0d, want 1 0 0 0 0 0",
               ready, valid, direction, dead_end, fallback, state_dbg);
    end
    tick(); tick();
    #3 reset = 1'b0;
    tick();
  endtask

  task automatic test_first_draw_hit();
    int e;
    for (int i = 0; i < 20; i++) lv_arr[i] = 11'b00000000010;
    run_txn(4'b0100, e);
    tests_run++;
    if (e !== 2 || direction !== DIR_SOUTH || fallback !== 1'b0 || dead_end !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_draw_hit: got edges=%0d dir=%0d fb=%b de=%b, want 2 2 0 0",
               e, direction, fallback, dead_end);
    end
    release_result();
  endtask

  task automatic test_dead_end();
    int e;
    run_txn(4'b0000, e);
    tests_run++;
    if (e !== 1 || dead_end !== 1'b1 || fallback !== 1'b0 || valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL dead_end: got edges=%0d de=%b fb=%b vld=%b, want 1 1 0 1",
               e, dead_end, fallback, valid);
    end
    release_result();
  endtask

  task automatic test_fallback();
    int e;
    for (int i = 0; i < 20; i++) lv_arr[i] = 11'd0;
    run_txn(4'b1000, e);
    tests_run++;
    if (e !== MAX_TRIES + 1 || direction !== DIR_WEST || fallback !== 1'b1 || dead_end !== 1'b0) begin
      tests_failed++;
      $display("FAIL fallback: got edges=%0d dir=%0d fb=%b de=%b, want %0d 3 1 0",
               e, direction, fallback, dead_end, MAX_TRIES + 1);
    end
    release_result();
  endtask

  task automatic test_hold_and_ack_request();
    int e;
    logic [1:0] d0;
    for (int i = 0; i < 20; i++) lv_arr[i] = 11'b00000000001;
    run_txn(4'b0010, e);
    d0 = 2'd1;
    for (int c = 0; c < 5; c++) begin
      lfsr_value = 11'($urandom); request = 1'($urandom); unvisited_mask = 4'($urandom);
      tick();
      tests_run++;
      if (valid !== 1'b1 || direction !== d0 || fallback !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_stable[%0d]: got vld=%b dir=%0d fb=%b, want 1 %0d 0",
                 c, valid, direction, fallback, d0);
      end
    end
    ack = 1'b1; request = 1'b1; unvisited_mask = 4'b0000;
    tick();
    ack = 1'b0; request = 1'b0;
    tests_run++;
    if (ready !== 1'b1 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_with_request: got rdy=%b vld=%b, want 1 0", ready, valid);
    end
    tick();
    tests_run++;
    if (ready !== 1'b1 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL request_not_queued: got rdy=%b vld=%b, want 1 0", ready, valid);
    end
  endtask

  task automatic test_idle_ack_ignored();
    ack = 1'b1;
    tick(); tick();
    ack = 1'b0;
    tests_run++;
    if (ready !== 1'b1 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_ack: got rdy=%b vld=%b, want 1 0", ready, valid);
    end
  endtask

  task automatic test_reset_async();
    int e;
    for (int i = 0; i < 20; i++) lv_arr[i] = 11'd0;
    request = 1'b1; unvisited_mask = 4'b1000; lfsr_value = 11'd0;
    tick();
    request = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (ready !== 1'b1 || valid !== 1'b0 || direction !== 2'd0 || dead_end !== 1'b0 ||
        fallback !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_sample: got rdy=%b vld=%b dir=%0d de=%b fb=%b, want 1 0 0 0 0",
               ready, valid, direction, dead_end, fallback);
    end
    tick();
    #3 reset = 1'b0;
    #1;
    // first request after reset must be taken on its first edge
    for (int i = 0; i < 20; i++) lv_arr[i] = 11'b00000000011;
    run_txn(4'b1000, e);
    tests_run++;
    if (e !== 2 || direction !== DIR_WEST || fallback !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_req_after_reset: got edges=%0d dir=%0d fb=%b, want 2 3 0",
               e, direction, fallback);
    end
    // reset while holding a result
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (ready !== 1'b1 || valid !== 1'b0 || direction !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_in_done: got rdy=%b vld=%b dir=%0d, want 1 0 0", ready, valid, direction);
    end
    #3 reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int e_act, e_exp, waitc;
    logic [1:0] d_exp;
    logic de_exp, fb_exp;
    logic [3:0] m;
    for (int n = 0; n < 60; n++) begin
      m = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) m = 4'(1 << $urandom_range(0, 3));
      for (int i = 0; i < 20; i++) lv_arr[i] = 11'($urandom);
      ref_model(m, e_exp, d_exp, de_exp, fb_exp);
      run_txn(m, e_act);
      tests_run++;
      if (e_act !== e_exp || dead_end !== de_exp || fallback !== fb_exp ||
          (!de_exp && direction !== d_exp)) begin
        tests_failed++;
        $display("FAIL random[%0d] mask=%b: got edges=%0d dir=%0d de=%b fb=%b, want %0d %0d %b %b",
                 n, m, e_act, direction, dead_end, fallback, e_exp, d_exp, de_exp, fb_exp);
      end
      waitc = $urandom_range(0, 2);
      for (int c = 0; c < waitc; c++) begin
        lfsr_value = 11'($urandom);
        tick();
      end
      release_result();
      tests_run++;
      if (ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL random_release[%0d]: got rdy=%b, want 1", n, ready);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_first_draw_hit();
    test_dead_end();
    test_fallback();
    test_hold_and_ack_request();
    test_idle_ack_ignored();
    test_reset_async();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
